// File: rtl/map9v3_sched.sv
// Two-requester round-robin scheduler driving a single map9v3 engine:
// launches a job, waits out any stale done, captures the result or aborts on timeout.
module map9v3_sched #(
  parameter int TIMEOUT   = 1024,
  parameter int START_CYC = 3
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       req0_valid_i,
  input  logic [8:0] req0_n_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic [8:0] req1_n_i,
  output logic       req1_ready_o,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic       rsp_id_o,
  output logic [8:0] rsp_dp_o,
  output logic [7:0] rsp_sr_o,
  output logic       rsp_err_o,
  output logic       m_start_o,
  output logic [8:0] m_n_o,
  input  logic       m_done_i,
  input  logic [8:0] m_dp_i,
  input  logic [7:0] m_sr_i,
  output logic       busy_o,
  output logic [2:0] state_o
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LAUNCH    = 3'd1;
  localparam logic [2:0] S_WAIT_CLR  = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RESULT    = 3'd4;

  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);
  localparam logic [7:0]  START_LAST = 8'(START_CYC - 1);

  // Handshakes: a request transfers in the cycle its ready is high (ready is only
  // ever high in IDLE); a response transfers when rsp_valid_o and rsp_ready_i are both high.
  logic [2:0]  state_q, state_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic [8:0]  mn_q, mn_d;
  logic [7:0]  lcnt_q, lcnt_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [8:0]  rsp_dp_q, rsp_dp_d;
  logic [7:0]  rsp_sr_q, rsp_sr_d;

  logic        any_valid;
  logic        grant;
  logic        grant_id;
  logic [15:0] tcnt_inc;
  logic        timeout_hit;

  always_comb begin
    any_valid   = req0_valid_i | req1_valid_i;
    // With both pending, serve the one not served last; otherwise whoever asks.
    grant_id    = (req0_valid_i && req1_valid_i) ? ~last_q : req1_valid_i;
    grant       = (state_q == S_IDLE) && any_valid && !reset_i;
    tcnt_inc    = (tcnt_q == 16'hFFFF) ? tcnt_q : tcnt_q + 16'd1;
    timeout_hit = (tcnt_q >= TO_LAST);
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    mn_d        = mn_q;
    lcnt_d      = lcnt_q;
    tcnt_d      = tcnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_dp_d    = rsp_dp_q;
    rsp_sr_d    = rsp_sr_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d = S_LAUNCH;
          id_d    = grant_id;
          last_d  = grant_id;
          mn_d    = grant_id ? req1_n_i : req0_n_i;
          lcnt_d  = 8'd0;
        end
      end
      S_LAUNCH: begin
        if (lcnt_q == START_LAST) begin
          state_d = S_WAIT_CLR;
          tcnt_d  = 16'd0;
        end else begin
          lcnt_d = lcnt_q + 8'd1;
        end
      end
      S_WAIT_CLR: begin
        tcnt_d = tcnt_inc;
        // A done still high here belongs to the previous job and is never captured.
        if (timeout_hit) begin
          state_d     = S_RESULT;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dp_d    = 9'd0;
          rsp_sr_d    = 8'd0;
        end else if (!m_done_i) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        tcnt_d = tcnt_inc;
        if (m_done_i) begin
          state_d     = S_RESULT;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dp_d    = m_dp_i;
          rsp_sr_d    = m_sr_i;
        end else if (timeout_hit) begin
          state_d     = S_RESULT;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dp_d    = 9'd0;
          rsp_sr_d    = 8'd0;
        end
      end
      S_RESULT: begin
        if (rsp_ready_i) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      mn_q        <= 9'd0;
      lcnt_q      <= 8'd0;
      tcnt_q      <= 16'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dp_q    <= 9'd0;
      rsp_sr_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      mn_q        <= mn_d;
      lcnt_q      <= lcnt_d;
      tcnt_q      <= tcnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dp_q    <= rsp_dp_d;
      rsp_sr_q    <= rsp_sr_d;
    end
  end

  assign req0_ready_o = grant & ~grant_id;
  assign req1_ready_o = grant & grant_id;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = id_q;
  assign rsp_dp_o     = rsp_dp_q;
  assign rsp_sr_o     = rsp_sr_q;
  assign rsp_err_o    = rsp_err_q;
  assign m_start_o    = (state_q == S_LAUNCH);
  assign m_n_o        = mn_q;
  assign busy_o       = (state_q != S_IDLE);
  assign state_o      = state_q;

endmodule

// File: tb/tb_map9v3_sched.sv
// Directed bench for map9v3_sched: behavioural engine model, grant and response
// scoreboards fed by the stimulus, checked by independent monitors.
module tb_map9v3_sched;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_CLR  = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RESULT    = 3'd4;

  logic       clock, reset;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [8:0] req0_n, req1_n;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [8:0] rsp_dp;
  logic [7:0] rsp_sr;
  logic       m_start, m_done;
  logic [8:0] m_n, m_dp;
  logic [7:0] m_sr;
  logic       busy;
  logic [2:0] state;

  typedef struct {
    int         lat;
    int         stale;
    bit         never;
    logic [8:0] dp;
    logic [7:0] sr;
  } eng_cfg_t;

  eng_cfg_t    eng_q[$];
  logic [9:0]  grant_q[$];   // {id, n}
  logic [18:0] exp_q[$];     // {id, dp, sr, err}
  logic [8:0]  cur_n;
  int          n_cmp = 0;
  int          n_bad = 0;

  map9v3_sched #(.TIMEOUT(16), .START_CYC(3)) dut (
    .clock_i(clock), .reset_i(reset),
    .req0_valid_i(req0_valid), .req0_n_i(req0_n), .req0_ready_o(req0_ready),
    .req1_valid_i(req1_valid), .req1_n_i(req1_n), .req1_ready_o(req1_ready),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_dp_o(rsp_dp), .rsp_sr_o(rsp_sr), .rsp_err_o(rsp_err),
    .m_start_o(m_start), .m_n_o(m_n), .m_done_i(m_done), .m_dp_i(m_dp), .m_sr_i(m_sr),
    .busy_o(busy), .state_o(state)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Engine model: done is a level that stays up until `stale` cycles after the next start ends.
  initial begin : engine
    eng_cfg_t cfg;
    m_done = 1'b0; m_dp = 9'd0; m_sr = 8'd0;
    forever begin
      @(negedge clock);
      if (m_start) begin
        while (m_start) @(negedge clock);
        if (eng_q.size() > 0) cfg = eng_q.pop_front();
        else cfg = '{lat: 0, stale: 0, never: 1'b1, dp: 9'd0, sr: 8'd0};
        repeat (cfg.stale) @(negedge clock);
        m_done = 1'b0;
        if (!cfg.never) begin
          repeat (cfg.lat) @(negedge clock);
          m_dp = cfg.dp; m_sr = cfg.sr; m_done = 1'b1;
        end
      end
    end
  end

  // Grant monitor: who was granted, operand on m_n, start pulse length
  initial begin : grant_mon
    logic [9:0] e;
    int cnt;
    forever begin
      @(negedge clock);
      if (req0_ready || req1_ready) begin
        if (grant_q.size() == 0) begin
          check("grant_unexpected", 32'({req1_ready, req0_ready}), 32'd0);
        end else begin
          e = grant_q.pop_front();
          cur_n = e[8:0];
          check("grant_id", 32'({req1_ready, req0_ready}), e[9] ? 32'd2 : 32'd1);
          @(negedge clock);
          check("m_n", 32'(m_n), 32'(e[8:0]));
          cnt = 0;
          while (m_start && cnt < 20) begin cnt++; @(negedge clock); end
          check("start_cycles", 32'(cnt), 32'd3);
        end
      end
    end
  end

  // Response monitor
  initial begin : rsp_mon
    logic [18:0] e;
    forever begin
      @(negedge clock);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'({rsp_id, rsp_dp, rsp_sr, rsp_err}), 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("rsp", 32'({rsp_id, rsp_dp, rsp_sr, rsp_err}), 32'(e));
          check("m_n_held", 32'(m_n), 32'(cur_n));
        end
      end
    end
  end

  // Driver tasks
  task automatic push_eng(input int lat, input int stale, input bit never,
                          input logic [8:0] dp, input logic [7:0] sr);
    eng_q.push_back('{lat: lat, stale: stale, never: never, dp: dp, sr: sr});
  endtask

  task automatic push_exp(input bit id, input logic [8:0] n, input logic [8:0] dp,
                          input logic [7:0] sr, input bit err);
    grant_q.push_back({id, n});
    exp_q.push_back({id, dp, sr, err});
  endtask

  task automatic wait_idle();
    int cnt = 0;
    @(negedge clock);
    while ((busy || rsp_valid) && cnt < 200) begin cnt++; @(negedge clock); end
    check("idle_wait_timeout", 32'(cnt >= 200), 32'd0);
  endtask

  task automatic wait_ready(input bit id);
    int cnt = 0;
    @(negedge clock);
    while (!(id ? req1_ready : req0_ready) && cnt < 50) begin cnt++; @(negedge clock); end
    check("grant_wait_timeout", 32'(cnt >= 50), 32'd0);
  endtask

  // Issues one request and follows it through; expectations must already be pushed.
  task automatic run_job(input bit id, input logic [8:0] n, input int stale, input bit measure);
    int cnt;
    @(posedge clock); #1;
    if (id) begin req1_valid = 1'b1; req1_n = n; end
    else begin req0_valid = 1'b1; req0_n = n; end
    wait_ready(id);
    @(posedge clock); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    cnt = 0;
    @(negedge clock);
    while (m_start && cnt < 50) begin cnt++; @(negedge clock); end
    for (int i = 0; i < stale; i++) begin
      check("stale_hold_wait_clr", 32'(state), 32'(S_WAIT_CLR));
      @(negedge clock);
    end
    if (measure) begin
      cnt = 0;
      while (!rsp_valid && cnt < 100) begin cnt++; @(negedge clock); end
      check("timeout_latency", 32'(cnt), 32'd16);
    end
    wait_idle();
  endtask

  initial begin : main
    int cnt;
    int grants;
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_n = 9'd0; req1_n = 9'd0; rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_m_start", 32'(m_start), 32'd0);
    check("rst_m_n", 32'(m_n), 32'd0);
    check("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    check("rst_rsp", 32'({rsp_valid, rsp_id, rsp_dp, rsp_sr, rsp_err}), 32'd0);

    // Single job, granted in the first cycle out of reset
    push_eng(4, 0, 1'b0, 9'h123, 8'h5A);
    push_exp(1'b0, 9'h0A5, 9'h123, 8'h5A, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0; req0_valid = 1'b1; req0_n = 9'h0A5;
    @(negedge clock);
    check("first_grant", 32'({req1_ready, req0_ready}), 32'd1);
    @(posedge clock); #1;
    req0_valid = 1'b0;
    wait_idle();

    // Stale done held 5 cycles into WAIT_CLR; old 123/5A must not be captured
    push_eng(3, 5, 1'b0, 9'h0F0, 8'hC3);
    push_exp(1'b1, 9'h1F0, 9'h0F0, 8'hC3, 1'b0);
    run_job(1'b1, 9'h1F0, 5, 1'b0);

    // Timeout boundaries: done on the 16th wait cycle wins; one later aborts
    push_eng(15, 0, 1'b0, 9'h155, 8'hAA);
    push_exp(1'b0, 9'h100, 9'h155, 8'hAA, 1'b0);
    run_job(1'b0, 9'h100, 0, 1'b0);
    push_eng(16, 0, 1'b0, 9'h1EE, 8'h11);
    push_exp(1'b1, 9'h0FF, 9'h000, 8'h00, 1'b1);
    run_job(1'b1, 9'h0FF, 0, 1'b0);
    push_eng(0, 0, 1'b1, 9'h000, 8'h00);
    push_exp(1'b0, 9'h07E, 9'h000, 8'h00, 1'b1);
    run_job(1'b0, 9'h07E, 0, 1'b1);

    // Backpressure: result held 10 cycles while req0 waits
    push_eng(2, 0, 1'b0, 9'h1AB, 8'h3C);
    push_exp(1'b1, 9'h033, 9'h1AB, 8'h3C, 1'b0);
    @(posedge clock); #1;
    rsp_ready = 1'b0; req1_valid = 1'b1; req1_n = 9'h033;
    wait_ready(1'b1);
    @(posedge clock); #1;
    req1_valid = 1'b0;
    cnt = 0;
    @(negedge clock);
    while (!rsp_valid && cnt < 100) begin cnt++; @(negedge clock); end
    check("bp_rsp_wait_timeout", 32'(cnt >= 100), 32'd0);
    push_eng(3, 0, 1'b0, 9'h0A0, 8'h0B);
    push_exp(1'b0, 9'h044, 9'h0A0, 8'h0B, 1'b0);
    @(posedge clock); #1;
    req0_valid = 1'b1; req0_n = 9'h044;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("bp_hold_rsp", 32'({rsp_valid, rsp_id, rsp_dp, rsp_sr, rsp_err}),
            32'({1'b1, 1'b1, 9'h1AB, 8'h3C, 1'b0}));
      check("bp_no_grant", 32'({req1_ready, req0_ready, state}), 32'({2'b00, S_RESULT}));
    end
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    wait_ready(1'b0);
    @(posedge clock); #1;
    req0_valid = 1'b0;
    wait_idle();

    // Reset while in WAIT_DONE drops the job silently
    push_eng(0, 0, 1'b1, 9'h000, 8'h00);
    grant_q.push_back({1'b0, 9'h0EE});
    @(posedge clock); #1;
    req0_valid = 1'b1; req0_n = 9'h0EE;
    wait_ready(1'b0);
    @(posedge clock); #1;
    req0_valid = 1'b0;
    cnt = 0;
    @(negedge clock);
    while (state != S_WAIT_DONE && cnt < 50) begin cnt++; @(negedge clock); end
    check("reach_wait_done_timeout", 32'(cnt >= 50), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("midjob_rst", 32'({busy, rsp_valid, state}), 32'({2'b00, S_IDLE}));

    push_eng(5, 0, 1'b0, 9'h0C7, 8'h71);
    push_exp(1'b1, 9'h1C7, 9'h0C7, 8'h71, 1'b0);
    run_job(1'b1, 9'h1C7, 0, 1'b0);

    // Contention: both held for four jobs, req1 served last -> 0,1,0,1
    push_eng(2, 0, 1'b0, 9'h1A1, 8'h10);
    push_exp(1'b0, 9'h011, 9'h1A1, 8'h10, 1'b0);
    push_eng(3, 0, 1'b0, 9'h0B2, 8'h20);
    push_exp(1'b1, 9'h122, 9'h0B2, 8'h20, 1'b0);
    push_eng(4, 0, 1'b0, 9'h1C3, 8'h30);
    push_exp(1'b0, 9'h011, 9'h1C3, 8'h30, 1'b0);
    push_eng(5, 0, 1'b0, 9'h0D4, 8'h40);
    push_exp(1'b1, 9'h122, 9'h0D4, 8'h40, 1'b0);
    @(posedge clock); #1;
    req0_valid = 1'b1; req0_n = 9'h011;
    req1_valid = 1'b1; req1_n = 9'h122;
    grants = 0; cnt = 0;
    while (grants < 4 && cnt < 400) begin
      @(negedge clock);
      cnt++;
      if (req0_ready || req1_ready) grants++;
      if (state != S_IDLE) check("ready_outside_idle", 32'({req1_ready, req0_ready}), 32'd0);
    end
    check("contention_timeout", 32'(cnt >= 400), 32'd0);
    @(posedge clock); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    // Final report
    cnt = 0;
    while ((exp_q.size() != 0 || grant_q.size() != 0) && cnt < 100) begin
      cnt++; @(negedge clock);
    end
    check("grant_q_drained", 32'(grant_q.size()), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("eng_q_drained", 32'(eng_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/map9v3_sched.md
MAP9V3_SCHED -- requirements
Module: map9v3_sched

Interface
REQ-001 Parameter TIMEOUT, default 1024: max cycles from end of start pulse to m_done before a job aborts.
REQ-002 Parameter START_CYC, default 3: number of cycles m_start is held high per launch.
REQ-003 clock  in  1  single clock; all flops on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req0_valid / req1_valid  in  1  requester 0/1 has a job pending.
REQ-006 req0_n / req1_n  in  9  job operand for requester 0/1; stable while its valid is high.
REQ-007 req0_ready / req1_ready  out  1  job accepted this cycle.
REQ-008 rsp_valid  out  1  result available.
REQ-009 rsp_ready  in  1  consumer takes result.
REQ-010 rsp_id  out  1  requester that owns the result.
REQ-011 rsp_dp  out  9  captured m_dp.
REQ-012 rsp_sr  out  8  captured m_sr.
REQ-013 rsp_err  out  1  job timed out.
REQ-014 m_start  out  1  start pulse to the map9v3 engine.
REQ-015 m_N  out  9  operand to the engine.
REQ-016 m_done  in  1  engine done level.
REQ-017 m_dp  in  9  engine dp result.
REQ-018 m_sr  in  8  engine sr result.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 FSM states: IDLE, LAUNCH, WAIT_CLR, WAIT_DONE, RESULT; exactly one active.
REQ-021 IDLE with any valid: grant one requester, pulse its ready for 1 cycle, latch its n into m_N and its id, go to LAUNCH.
REQ-022 Arbitration is round-robin: if both valid, grant the requester not served last; if one valid, grant it regardless of the pointer.
REQ-023 The last-served pointer updates only on a grant; it resets to 1, so req0 wins the first contention.
REQ-024 LAUNCH: m_start=1 for exactly START_CYC cycles, then go to WAIT_CLR.
REQ-025 WAIT_CLR: wait for m_done=0, which clears a stale done from the previous job; then go to WAIT_DONE.
REQ-026 WAIT_DONE: on m_done=1, capture m_dp/m_sr into rsp_dp/rsp_sr, set rsp_err=0, go to RESULT.
REQ-027 Timeout counter: 16 bits, cleared on leaving LAUNCH, increments in WAIT_CLR and WAIT_DONE, saturates.
REQ-028 Abort: if the counter reaches TIMEOUT before capture, enter RESULT with rsp_err=1, rsp_dp=0, rsp_sr=0.
REQ-029 If m_done=1 in the same cycle the counter reaches TIMEOUT, the done path wins (rsp_err=0).
REQ-030 RESULT: rsp_valid=1 and rsp_* held stable; when rsp_ready=1, go to IDLE next cycle.
REQ-031 No grant occurs in the RESULT-to-IDLE transfer cycle; the earliest grant is the cycle after returning to IDLE.
REQ-032 m_N is held constant from grant until leaving RESULT; ready outputs are 0 outside IDLE.
REQ-033 rsp_valid is registered; rsp_ready is ignored outside RESULT.

Reset
REQ-034 On reset: state=IDLE, m_start=0, m_N=0, all ready=0, rsp_valid=0, rsp_id=0, rsp_dp=0, rsp_sr=0, rsp_err=0, busy=0, counter=0, pointer=1.
REQ-035 Reset asserted mid-job forces IDLE next cycle; the in-flight job is dropped with no response.
REQ-036 First grant is possible in the first cycle after reset deasserts.

Verification
REQ-037 Single job: req0_valid, n=9'h0A5; engine model asserts done with dp=9'h123, sr=8'h5A -> req0_ready 1 cycle; m_start high 3 cycles; rsp_valid with id=0, dp=9'h123, sr=8'h5A, err=0.
REQ-038 Contention: both valid continuously for 4 jobs -> grant order 0,1,0,1; m_N matches the granted n each time.
REQ-039 Stale done: m_done held 1 from the prior job -> FSM stays in WAIT_CLR until done drops; no early capture.
REQ-040 Timeout: TIMEOUT=16, engine never asserts done -> rsp_valid with err=1, dp=0, sr=0, 16 cycles after LAUNCH ends.
REQ-041 Backpressure: rsp_ready=0 for 10 cycles -> rsp_* stable, no new grant, req ready=0 throughout.
REQ-042 Reset in WAIT_DONE -> next cycle busy=0, rsp_valid=0; a subsequent req1 job completes normally.
